// File: rtl/imm_gen_stage_if.sv
// Handshake/bus bundle for imm_gen_stage: upstream instruction stream in,
// decoded immediate stream out. Master drives the inputs of the stage.
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr_in;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_out;
  logic [2:0]       imm_type;
  logic [TAG_W-1:0] tag_out;
  logic             illegal_out;

  modport master (
    output flush, in_valid, instr_in, tag_in, out_ready,
    input  in_ready, out_valid, imm_out, imm_type, tag_out, illegal_out
  );

  modport slave (
    input  flush, in_valid, instr_in, tag_in, out_ready,
    output in_ready, out_valid, imm_out, imm_type, tag_out, illegal_out
  );
endinterface

// File: rtl/imm_gen_stage.sv
// RISC-V immediate generator behind a 2-entry skid buffer (latency 1).
// Optional CSR zimm decode (type Z) enabled by macro IMM_GEN_ZICSR_EN.
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  imm_gen_stage_if.slave  bus
);

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_kind_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MAIN  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       kind;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  state_t    state_q, state_d;
  entry_t    main_q, skid_q, dec;
  imm_kind_t kind;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x;
  logic [31:0]     ins;
  logic            accept, load_main, load_skid, promote;

  assign ins = bus.instr_in;

  always_comb begin
    kind  = IMM_NONE;
    imm32 = '0;
    case (ins[6:2])
      5'b00000, 5'b00100, 5'b11001: begin
        kind  = IMM_I;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      5'b01000: begin
        kind  = IMM_S;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      5'b11000: begin
        kind  = IMM_B;
        imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      5'b01101, 5'b00101: begin
        kind  = IMM_U;
        imm32 = {ins[31:12], 12'h000};
      end
      5'b11011: begin
        kind  = IMM_J;
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: ;
    endcase
    imm_x = XLEN'($signed(imm32));
`ifdef IMM_GEN_ZICSR_EN
    if (ins[6:2] == 5'b11100 && ins[14]) begin
      kind  = IMM_Z;
      imm_x = XLEN'(ins[19:15]);
    end
`endif
    dec.tag     = bus.tag_in;
    dec.illegal = 1'b0;
    dec.kind    = kind;
    dec.imm     = imm_x;
    if (ins[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
      dec.kind    = IMM_NONE;
      dec.imm     = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    promote   = 1'b0;
    accept    = bus.in_valid && (state_q != S_FULL);
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d   = S_MAIN;
          load_main = 1'b1;
        end
      end
      S_MAIN: begin
        if (accept && bus.out_ready) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = S_FULL;
          load_skid = 1'b1;
        end else if (bus.out_ready) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (bus.out_ready) begin
          state_d = S_MAIN;
          promote = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush wins over both accept and drain; stale slot contents are masked
    // at the outputs by the EMPTY state, so no data update is needed.
    if (bus.flush) begin
      state_d   = S_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      promote   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main) begin
        main_q <= dec;
      end else if (promote) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  always_comb begin
    bus.out_valid   = (state_q != S_EMPTY);
    bus.in_ready    = (state_q != S_FULL);
    bus.imm_out     = bus.out_valid ? main_q.imm     : '0;
    bus.imm_type    = bus.out_valid ? main_q.kind    : '0;
    bus.tag_out     = bus.out_valid ? main_q.tag     : '0;
    bus.illegal_out = bus.out_valid ? main_q.illegal : 1'b0;
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: directed steps plus a scoreboard of
// expected entries, with an XLEN=64 instance for sign-extension cases.
module tb_imm_gen_stage;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(16)) bus64 ();

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(16)) dut64 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus64)
  );

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  kind;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] tg);
    exp_t e;
    e     = '0;
    e.tag = tg;
    if (i[1:0] != 2'b11) begin
      e.ill = 1'b1;
      return e;
    end
    case (i[6:2])
      5'b00000, 5'b00100, 5'b11001: begin
        e.kind = 3'd1; e.imm = {{20{i[31]}}, i[31:20]};
      end
      5'b01000: begin
        e.kind = 3'd2; e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      5'b11000: begin
        e.kind = 3'd3; e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      5'b01101, 5'b00101: begin
        e.kind = 3'd4; e.imm = {i[31:12], 12'h000};
      end
      5'b11011: begin
        e.kind = 3'd5; e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
`ifdef IMM_GEN_ZICSR_EN
      5'b11100: begin
        if (i[14]) begin
          e.kind = 3'd6; e.imm = {27'd0, i[19:15]};
        end
      end
`endif
      default: ;
    endcase
    return e;
  endfunction

  // One clock of the 32-bit DUT: drive, score the handshake, advance.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                      input logic ordy, input logic fl, input logic rn);
    logic acc, pop;
    exp_t e;
    bus32.in_valid  = v;
    bus32.instr_in  = ins;
    bus32.tag_in    = tg;
    bus32.out_ready = ordy;
    bus32.flush     = fl;
    reset_n         = rn;
    #1;
    acc = rn && !fl && v && bus32.in_ready;
    pop = rn && !fl && bus32.out_valid && ordy;
    if (pop) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_imm",  64'(bus32.imm_out),     64'(e.imm));
        chk("pop_type", 64'(bus32.imm_type),    64'(e.kind));
        chk("pop_tag",  64'(bus32.tag_out),     64'(e.tag));
        chk("pop_ill",  64'(bus32.illegal_out), 64'(e.ill));
      end
    end
    @(posedge clk);
    if (!rn || fl) sb.delete();
    if (acc) sb.push_back(model(ins, tg));
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_ovalid"}, 64'(bus32.out_valid),   64'd0);
    chk({name, "_iready"}, 64'(bus32.in_ready),    64'd1);
    chk({name, "_imm"},    64'(bus32.imm_out),     64'd0);
    chk({name, "_type"},   64'(bus32.imm_type),    64'd0);
    chk({name, "_tag"},    64'(bus32.tag_out),     64'd0);
    chk({name, "_ill"},    64'(bus32.illegal_out), 64'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [4:0]  ops [11];
    ops = '{5'b00000, 5'b00100, 5'b11001, 5'b01000, 5'b11000, 5'b01101,
            5'b00101, 5'b11011, 5'b11100, 5'b01100, 5'b00011};

    bus32.in_valid = 0; bus32.instr_in = '0; bus32.tag_in = '0;
    bus32.out_ready = 0; bus32.flush = 0;
    bus64.in_valid = 0; bus64.instr_in = '0; bus64.tag_in = '0;
    bus64.out_ready = 1; bus64.flush = 0;

    // Reset state
    reset_n = 0;
    @(posedge clk); @(posedge clk); #1;
    chk_idle("reset");

    // Directed decode, streaming with out_ready=1
    step(1, 32'hFFF00093, 32'h100, 1, 0, 1);
    chk("addi_valid", 64'(bus32.out_valid), 64'd1);
    chk("addi_imm",   64'(bus32.imm_out),   64'hFFFFFFFF);
    chk("addi_type",  64'(bus32.imm_type),  64'd1);
    step(1, 32'hFE112E23, 32'h104, 1, 0, 1);
    chk("sw_imm",  64'(bus32.imm_out),  64'hFFFFFFFC);
    chk("sw_type", 64'(bus32.imm_type), 64'd2);
    step(1, 32'h001000EF, 32'h108, 1, 0, 1);
    chk("jal_imm",  64'(bus32.imm_out),  64'h00000800);
    chk("jal_type", 64'(bus32.imm_type), 64'd5);
    step(1, 32'h800000B7, 32'h10C, 1, 0, 1);
    chk("lui32_imm",  64'(bus32.imm_out),  64'h80000000);
    chk("lui32_type", 64'(bus32.imm_type), 64'd4);
    step(1, 32'h00000090, 32'h110, 1, 0, 1);
    chk("ill_flag", 64'(bus32.illegal_out), 64'd1);
    chk("ill_imm",  64'(bus32.imm_out),     64'd0);
    chk("ill_type", 64'(bus32.imm_type),    64'd0);
    step(1, 32'h300FD073, 32'h114, 1, 0, 1);
`ifdef IMM_GEN_ZICSR_EN
    chk("csr_imm",  64'(bus32.imm_out),  64'h1F);
    chk("csr_type", 64'(bus32.imm_type), 64'd6);
`else
    chk("csr_imm",  64'(bus32.imm_out),  64'd0);
    chk("csr_type", 64'(bus32.imm_type), 64'd0);
`endif
    step(0, 32'h0, 32'h0, 1, 0, 1);
    chk_idle("drain");

    // Backpressure: third back-to-back input is refused
    step(1, 32'h00A00093, 32'h200, 0, 0, 1);
    chk("bp1_iready", 64'(bus32.in_ready), 64'd1);
    step(1, 32'h00B00113, 32'h204, 0, 0, 1);
    chk("bp2_iready", 64'(bus32.in_ready), 64'd0);
    step(1, 32'h00C00193, 32'h208, 0, 0, 1);
    chk("bp3_iready", 64'(bus32.in_ready), 64'd0);
    chk("bp3_tag",    64'(bus32.tag_out),  64'h200);
    chk("bp3_imm",    64'(bus32.imm_out),  64'h00A);
    step(0, 32'h0, 32'h0, 1, 0, 1);
    chk("bp4_iready", 64'(bus32.in_ready), 64'd1);
    chk("bp4_tag",    64'(bus32.tag_out),  64'h204);
    step(0, 32'h0, 32'h0, 1, 0, 1);
    chk("bp5_ovalid", 64'(bus32.out_valid), 64'd0);
    chk("bp5_sb",     64'(sb.size()),       64'd0);

    // Flush in FULL with a valid input
    step(1, 32'h00100093, 32'h300, 0, 0, 1);
    step(1, 32'h00200093, 32'h304, 0, 0, 1);
    step(1, 32'h00300093, 32'h308, 0, 1, 1);
    chk("flush_ovalid", 64'(bus32.out_valid), 64'd0);
    chk("flush_iready", 64'(bus32.in_ready),  64'd1);
    step(0, 32'h0, 32'h0, 1, 0, 1);
    chk("flush_nodrop", 64'(bus32.out_valid), 64'd0);

    // Reset mid-stream with a valid input
    step(1, 32'h00400093, 32'h400, 0, 0, 1);
    step(1, 32'h00500093, 32'h404, 0, 0, 1);
    step(1, 32'h00600093, 32'h408, 0, 1, 0);
    chk_idle("midrst");
    step(0, 32'h0, 32'h0, 1, 0, 1);
    chk("midrst_nodrop", 64'(bus32.out_valid), 64'd0);

    // Random stream against the scoreboard
    for (int unsigned k = 0; k < 400; k++) begin
      r = $urandom();
      r[6:2] = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 7) != 0) r[1:0] = 2'b11;
      step(logic'($urandom_range(0, 3) != 0), r, 32'h1000 + k,
           logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 49) == 0), 1);
    end
    for (int unsigned k = 0; k < 8 && sb.size() != 0; k++)
      step(0, 32'h0, 32'h0, 1, 0, 1);
    chk("final_sb", 64'(sb.size()), 64'd0);
    step(0, 32'h0, 32'h0, 1, 0, 1);
    chk("final_ovalid", 64'(bus32.out_valid), 64'd0);

    // XLEN=64 instance: U-type sign extension and illegal encoding
    bus64.in_valid = 1; bus64.instr_in = 32'h800000B7; bus64.tag_in = 16'hA5;
    @(posedge clk); #1;
    chk("lui64_imm",  bus64.imm_out,         64'hFFFFFFFF80000000);
    chk("lui64_type", 64'(bus64.imm_type),   64'd4);
    chk("lui64_tag",  64'(bus64.tag_out),    64'hA5);
    bus64.instr_in = 32'h00000090; bus64.tag_in = 16'hA6;
    @(posedge clk); #1;
    chk("ill64_flag", 64'(bus64.illegal_out), 64'd1);
    chk("ill64_imm",  bus64.imm_out,          64'd0);
    bus64.instr_in = 32'hFFF00093; bus64.tag_in = 16'hA7;
    @(posedge clk); #1;
    chk("addi64_imm", bus64.imm_out, 64'hFFFFFFFFFFFFFFFF);
    bus64.in_valid = 0;
    @(posedge clk); #1;
    chk("idle64_ovalid", 64'(bus64.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 32, width of the sideband tag (typically the PC) carried alongside each instruction.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush  input  1  discards all held entries.
REQ-006 SHALL have port in_valid  input  1  instr_in/tag_in valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept; registered.
REQ-008 SHALL have port instr_in  input  32  raw instruction word.
REQ-009 SHALL have port tag_in  input  TAG_W  sideband, passed through unmodified.
REQ-010 SHALL have port out_valid  output  1  output entry valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the output entry.
REQ-012 SHALL have port imm_out  output  XLEN  decoded, extended immediate.
REQ-013 SHALL have port imm_type  output  3  0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (CSR zimm).
REQ-014 SHALL have port tag_out  output  TAG_W  tag of the output entry.
REQ-015 SHALL have port illegal_out  output  1  instr_in[1:0] != 2'b11.

Function
REQ-016 SHALL decode on instr[6:2]: 00000/00100/11001 -> I; 01000 -> S; 11000 -> B; 01101/00101 -> U; 11011 -> J; all other opcodes -> NONE with imm 0.
REQ-017 SHALL build immediates as follows: I = instr[31:20]; S = {instr[31:25],instr[11:7]}; B = {instr[31],instr[7],instr[30:25],instr[11:8],0}; U = {instr[31:12],12'b0}; J = {instr[31],instr[19:12],instr[20],instr[30:21],0}.
REQ-018 SHALL sign-extend every immediate from instr[31] to XLEN, including U-type when XLEN=64.
REQ-019 SHALL, when instr[1:0] != 2'b11, set illegal_out=1, imm_type=NONE and imm_out=0.
REQ-020 SHALL accept an entry on a clock edge when in_valid && in_ready, and present it one cycle later (latency 1).
REQ-021 SHALL be a 2-entry skid buffer with states EMPTY, MAIN and FULL, where out_valid = (state != EMPTY) and in_ready = (state != FULL).
REQ-022 SHALL make these transitions: EMPTY + accept -> MAIN; MAIN + accept + !out_ready -> FULL, with the new entry held in the skid slot; MAIN + accept + out_ready -> MAIN, replaced by the new entry; MAIN + !accept + out_ready -> EMPTY; FULL + out_ready -> MAIN, skid entry promoted; otherwise hold.
REQ-023 SHALL deliver entries in acceptance order, with no loss and no duplication under any out_ready pattern.
REQ-024 SHALL hold output fields stable while out_valid && !out_ready.
REQ-025 SHALL give flush priority over accept and drain: the next state is EMPTY and any in_valid in the flush cycle is dropped.
REQ-026 SHALL drive don't-care outputs to 0 when out_valid=0.

Reset
REQ-027 SHALL, on reset_n=0 at a clock edge, go to state EMPTY and set out_valid=0, in_ready=1, imm_out=0, imm_type=0, tag_out=0 and illegal_out=0.
REQ-028 SHALL, on reset mid-operation, discard held entries exactly as flush does; reset overrides flush and accept.

Configuration
REQ-029 SHALL support macro IMM_GEN_ZICSR_EN.
REQ-030 SHALL, with IMM_GEN_ZICSR_EN defined, decode opcode 11100 with funct3[2]=1 as type Z, imm_out = zero-extended instr[19:15].
REQ-031 SHALL, without IMM_GEN_ZICSR_EN, treat opcode 11100 as NONE with imm 0; imm_type code 6 is then never produced.

Verification
REQ-032 SHALL verify: 0xFFF00093 (addi x1,x0,-1) -> one cycle later imm_out=0xFFFFFFFF, imm_type=1.
REQ-033 SHALL verify: 0xFE112E23 (sw x1,-4(x2)) -> imm_out=0xFFFFFFFC, imm_type=2; 0x001000EF (jal x1,2048) -> imm_out=0x00000800, imm_type=5.
REQ-034 SHALL verify: XLEN=64 with 0x800000B7 (lui x1,0x80000) -> imm_out=0xFFFFFFFF80000000, imm_type=4; 0x00000090 -> illegal_out=1, imm_out=0.
REQ-035 SHALL verify: out_ready=0 with three back-to-back valid inputs -> two accepted, in_ready=0 from the third cycle; then out_ready=1 -> entries emerge in order with matching tags, in_ready returns to 1.
REQ-036 SHALL verify: flush asserted in state FULL with in_valid=1 -> next cycle out_valid=0 and in_ready=1, and the flush-cycle input is never output; reset_n=0 mid-stream -> same.
REQ-037 SHALL verify: 0x300FD073 (csrrwi x0,0x300,31) -> with IMM_GEN_ZICSR_EN imm_out=0x1F, imm_type=6; without it imm_out=0, imm_type=0.
